bp_fe_queue_roll: RTL and testbench

//  FE->BE instruction queue with a speculative read pointer and a committed pointer.

---
 rtl/bp_fe_queue_roll_pkg.sv | 12 +
 rtl/bp_fe_queue_roll_if.sv | 31 +++
 rtl/bp_fe_queue_roll_mem.sv | 28 ++
 rtl/bp_fe_queue_roll.sv | 91 +++++++++
 tb/tb_bp_fe_queue_roll.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/bp_fe_queue_roll_pkg.sv
// Shared constants and pointer-width helper for the FE->BE roll-back instruction queue.
package bp_fe_queue_roll_pkg;

  localparam int unsigned fe_queue_width_default_p = 128;
  localparam int unsigned fe_queue_els_default_p   = 8;

  // Pointers carry one extra wrap bit above the storage index.
  function automatic int unsigned ptr_width(input int unsigned els);
    return $clog2(els) + 1;
  endfunction

endpackage

// File: rtl/bp_fe_queue_roll_if.sv
// fe_queue port bundle between FE producer, the queue and the BE consumer.
// Signal suffixes are relative to the queue: the slave modport is the queue itself.
interface bp_fe_queue_roll_if
  import bp_fe_queue_roll_pkg::*;
#(
  parameter int unsigned width_p = fe_queue_width_default_p
) ();

  logic [width_p-1:0] fe_queue_i;
  logic               fe_queue_v_i;
  logic               fe_queue_ready_o;
  logic [width_p-1:0] fe_queue_o;
  logic               fe_queue_v_o;
  logic               fe_queue_yumi_i;
  logic               fe_queue_deq_i;
  logic               fe_queue_roll_i;
  logic               fe_queue_clr_i;

  modport slave (
    input  fe_queue_i, fe_queue_v_i, fe_queue_yumi_i,
           fe_queue_deq_i, fe_queue_roll_i, fe_queue_clr_i,
    output fe_queue_ready_o, fe_queue_o, fe_queue_v_o
  );

  modport master (
    output fe_queue_i, fe_queue_v_i, fe_queue_yumi_i,
           fe_queue_deq_i, fe_queue_roll_i, fe_queue_clr_i,
    input  fe_queue_ready_o, fe_queue_o, fe_queue_v_o
  );

endinterface

// File: rtl/bp_fe_queue_roll_mem.sv
// One-write one-read register-file storage with synchronous write and combinational read.
module bp_fe_queue_roll_mem
  import bp_fe_queue_roll_pkg::*;
#(
  parameter int unsigned width_p = fe_queue_width_default_p,
  parameter int unsigned els_p   = fe_queue_els_default_p,
  localparam int unsigned addr_w_lp = $clog2(els_p)
) (
  input  logic                 clk_i,
  input  logic                 w_v_i,
  input  logic [addr_w_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]   w_data_i,
  input  logic [addr_w_lp-1:0] r_addr_i,
  output logic [width_p-1:0]   r_data_o
);

  logic [width_p-1:0] mem_q [els_p];

  // Contents are never reset; the queue pointers decide which entries are live.
  always_ff @(posedge clk_i) begin
    if (w_v_i) begin
      mem_q[w_addr_i] <= w_data_i;
    end
  end

  assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/bp_fe_queue_roll.sv
// FE->BE instruction queue with speculative read pointer and committed pointer (roll/deq/clr).
// Optional BP_FE_QUEUE_BYPASS_EN: an enq into an empty queue is visible on fe_queue_o that cycle.
module bp_fe_queue_roll
  import bp_fe_queue_roll_pkg::*;
#(
  parameter int unsigned width_p = fe_queue_width_default_p,
  parameter int unsigned els_p   = fe_queue_els_default_p
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  bp_fe_queue_roll_if.slave  fe_if
);

  localparam int unsigned ptr_w_lp = ptr_width(els_p);
  localparam int unsigned idx_w_lp = ptr_w_lp - 1;

  logic [ptr_w_lp-1:0] wptr_q, wptr_d;
  logic [ptr_w_lp-1:0] rptr_q, rptr_d;
  logic [ptr_w_lp-1:0] cptr_q, cptr_d;
  logic [ptr_w_lp-1:0] cptr_inc;
  logic                full, read_empty, enq_v;
  logic                yumi, deq, roll, clr;
  logic [width_p-1:0]  mem_data;

  assign yumi = fe_if.fe_queue_yumi_i;
  assign deq  = fe_if.fe_queue_deq_i;
  assign roll = fe_if.fe_queue_roll_i;
  assign clr  = fe_if.fe_queue_clr_i;

  // Full is measured against the committed pointer: consumed entries still occupy storage.
  assign full       = (wptr_q[idx_w_lp-1:0] == cptr_q[idx_w_lp-1:0])
                    & (wptr_q[idx_w_lp] != cptr_q[idx_w_lp]);
  assign read_empty = (rptr_q == wptr_q);
  assign enq_v      = fe_if.fe_queue_v_i & ~full & ~clr;

  assign fe_if.fe_queue_ready_o = ~full;

  assign cptr_inc = cptr_q + ptr_w_lp'(deq);

  always_comb begin
    wptr_d = wptr_q + ptr_w_lp'(enq_v);
    cptr_d = cptr_inc;
    rptr_d = rptr_q + ptr_w_lp'(yumi);
    if (clr) begin
      cptr_d = wptr_q;
      rptr_d = wptr_q;
    end else if (roll) begin
      rptr_d = cptr_inc;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cptr_q <= cptr_d;
    end
  end

  bp_fe_queue_roll_mem #(
    .width_p (width_p),
    .els_p   (els_p)
  ) mem (
    .clk_i    (clk_i),
    .w_v_i    (enq_v),
    .w_addr_i (wptr_q[idx_w_lp-1:0]),
    .w_data_i (fe_if.fe_queue_i),
    .r_addr_i (rptr_q[idx_w_lp-1:0]),
    .r_data_o (mem_data)
  );

`ifdef BP_FE_QUEUE_BYPASS_EN
  assign fe_if.fe_queue_v_o = ~read_empty | (enq_v & ~roll);
  assign fe_if.fe_queue_o   = read_empty ? fe_if.fe_queue_i : mem_data;
`else
  assign fe_if.fe_queue_v_o = ~read_empty;
  assign fe_if.fe_queue_o   = mem_data;
`endif

  // Yumi is only meaningful when it is not overridden by roll or clr.
  yumi_legal_a : assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (yumi & ~roll & ~clr) |-> fe_if.fe_queue_v_o);

  deq_legal_a : assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (deq & ~clr) |-> (cptr_q != rptr_q));

endmodule

// File: tb/tb_bp_fe_queue_roll.sv
// Self-checking bench for bp_fe_queue_roll (width 8, depth 4) against a queue-level model.
module tb_bp_fe_queue_roll;

  localparam int queueWidth = 8;
  localparam int queueDepth = 4;

  logic clk = 1'b0;
  logic resetN = 1'b0;

  always #5 clk = ~clk;

  bp_fe_queue_roll_if #(.width_p(queueWidth)) qIf ();

  bp_fe_queue_roll #(
    .width_p (queueWidth),
    .els_p   (queueDepth)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (resetN),
    .fe_if     (qIf)
  );

  int vectorCount = 0;
  int missCount = 0;
  bit checkEn = 1'b0;

  // Model: live entries from the oldest uncommitted one, plus how many have been consumed.
  logic [queueWidth-1:0] store[$];
  int readOff = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [queueWidth-1:0] d,
                               input logic y, input logic dq, input logic rl, input logic cl);
    qIf.fe_queue_v_i    = v;
    qIf.fe_queue_i      = d;
    qIf.fe_queue_yumi_i = y;
    qIf.fe_queue_deq_i  = dq;
    qIf.fe_queue_roll_i = rl;
    qIf.fe_queue_clr_i  = cl;
    @(posedge clk);
    #1;
    qIf.fe_queue_v_i    = 1'b0;
    qIf.fe_queue_i      = '0;
    qIf.fe_queue_yumi_i = 1'b0;
    qIf.fe_queue_deq_i  = 1'b0;
    qIf.fe_queue_roll_i = 1'b0;
    qIf.fe_queue_clr_i  = 1'b0;
  endtask

  // Model update: enq first (room judged on the pre-cycle size), then retire, then rewind or consume.
  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      store.delete();
      readOff = 0;
    end else if (qIf.fe_queue_clr_i) begin
      store.delete();
      readOff = 0;
    end else begin
      if (qIf.fe_queue_v_i && store.size() < queueDepth) store.push_back(qIf.fe_queue_i);
      if (qIf.fe_queue_deq_i) begin
        void'(store.pop_front());
        readOff--;
      end
      if (qIf.fe_queue_roll_i) readOff = 0;
      else if (qIf.fe_queue_yumi_i) readOff++;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("v_o", {31'b0, qIf.fe_queue_v_o}, {31'b0, readOff < store.size()});
      checkOutput("ready_o", {31'b0, qIf.fe_queue_ready_o}, {31'b0, store.size() < queueDepth});
      if (readOff < store.size())
        checkOutput("data_o", {24'b0, qIf.fe_queue_o}, {24'b0, store[readOff]});
    end
  end

  initial begin
    logic doEnq, doYumi, doDeq;
    int enqCount, outCount, cycles;
    bit resetDone;

    qIf.fe_queue_v_i    = 1'b0;
    qIf.fe_queue_i      = '0;
    qIf.fe_queue_yumi_i = 1'b0;
    qIf.fe_queue_deq_i  = 1'b0;
    qIf.fe_queue_roll_i = 1'b0;
    qIf.fe_queue_clr_i  = 1'b0;

    #12;
    checkOutput("rst_v", {31'b0, qIf.fe_queue_v_o}, 32'd0);
    checkOutput("rst_ready", {31'b0, qIf.fe_queue_ready_o}, 32'd1);
    resetN = 1'b1;
    @(posedge clk);
    #1;
    checkEn = 1'b1;

    // Fill, first-entry latency, full and held fifth enq.
    applyStimulus(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lat_v", {31'b0, qIf.fe_queue_v_o}, 32'd1);
    checkOutput("lat_data", {24'b0, qIf.fe_queue_o}, 32'hA1);
    for (int i = 2; i <= 4; i++) applyStimulus(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("full_ready", {31'b0, qIf.fe_queue_ready_o}, 32'd0);
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("held_data", {24'b0, qIf.fe_queue_o}, 32'hA1);

    // Consume two, retire one, roll back and replay.
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("yumi2_data", {24'b0, qIf.fe_queue_o}, 32'hA3);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("roll_v", {31'b0, qIf.fe_queue_v_o}, 32'd1);
    checkOutput("roll_data", {24'b0, qIf.fe_queue_o}, 32'hA2);
    for (int i = 0; i < 3; i++) begin
      checkOutput("replay", {24'b0, qIf.fe_queue_o}, 32'(8'hA2 + i));
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("replay_done_v", {31'b0, qIf.fe_queue_v_o}, 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

    // Everything consumed but uncommitted still blocks the producer.
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 8'(8'h90 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("consumed_v", {31'b0, qIf.fe_queue_v_o}, 32'd0);
    checkOutput("consumed_ready", {31'b0, qIf.fe_queue_ready_o}, 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("deq_ready", {31'b0, qIf.fe_queue_ready_o}, 32'd1);
    applyStimulus(1'b1, 8'hB0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("b0_data", {24'b0, qIf.fe_queue_o}, 32'hB0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

    // Clear discards the same-cycle enq.
    applyStimulus(1'b1, 8'h51, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hC0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("clr_v", {31'b0, qIf.fe_queue_v_o}, 32'd0);
    checkOutput("clr_ready", {31'b0, qIf.fe_queue_ready_o}, 32'd1);
    applyStimulus(1'b1, 8'h52, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("post_clr_data", {24'b0, qIf.fe_queue_o}, 32'h52);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

    // Roll with same-cycle deq and yumi: lands on the second consumed entry.
    for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 8'(8'hE0 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("rdy_roll_v", {31'b0, qIf.fe_queue_v_o}, 32'd1);
    checkOutput("rdy_roll_data", {24'b0, qIf.fe_queue_o}, 32'hE2);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

    // Gapped traffic across several pointer wraps, then an asynchronous reset.
    enqCount = 0;
    outCount = 0;
    cycles = 0;
    resetDone = 1'b0;
    while (!resetDone && cycles < 400) begin
      doEnq  = (enqCount < 20) && (store.size() < queueDepth) && ($urandom_range(0, 2) != 0);
      doYumi = (readOff < store.size()) && ($urandom_range(0, 1) == 1);
      doDeq  = (readOff > 0) && ($urandom_range(0, 2) == 0);
      if (doYumi) begin
        checkOutput("order", {24'b0, qIf.fe_queue_o}, 32'(8'h10 + outCount));
        outCount++;
      end
      applyStimulus(doEnq, 8'(8'h10 + enqCount), doYumi, doDeq, 1'b0, 1'b0);
      if (doEnq) enqCount++;
      cycles++;
      if (outCount == 16) begin
        #2;
        resetN = 1'b0;
        #1;
        checkOutput("async_rst_v", {31'b0, qIf.fe_queue_v_o}, 32'd0);
        checkOutput("async_rst_ready", {31'b0, qIf.fe_queue_ready_o}, 32'd1);
        #3;
        resetN = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("post_rst_v", {31'b0, qIf.fe_queue_v_o}, 32'd0);
        resetDone = 1'b1;
      end
    end
    if (!resetDone) begin
      vectorCount++;
      missCount++;
      $display("[TB] FAIL wrap_sequence: got %0d outputs, expected 16 within 400 cycles", outCount);
    end

    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
